t05_spi_flash_reader: RTL and testbench



---
 rtl/t05_spi_flash_reader.sv | 234 +++++++++++++++++++++++
 tb/tb_t05_spi_flash_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/t05_spi_flash_reader.sv
// t05_spi_flash_reader
//   SPI mode-0 master that streams the raw input file out of serial flash.
//   Sends a READ command plus a 24-bit address on mosi. It then shifts miso
//   into bytes (MSB first) and hands each byte to the downstream histogram
//   stage over a valid/ready handshake. At a byte boundary, sclk is parked
//   low while the consumer still holds an unaccepted byte, so data is never
//   overwritten.
//
//   Optional macro T05_SPI_FAST_READ_EN: when defined, the command byte is
//   FAST READ (0x0B). Eight dummy sclk cycles with mosi=0 are then inserted
//   between the address and the data phase. When it is undefined, plain
//   READ (0x03) is used and no dummy phase exists.
//
// Ports
//   hwclk        system clock, rising edge
//   reset        synchronous active-high reset
//   start        one-cycle request, honoured only while idle
//   start_addr   first flash byte address, latched on accepted start
//   byte_count   number of bytes to read, latched on accepted start
//   sclk         SPI clock, idles low
//   cs_n         flash chip select, active low
//   mosi         command/address serial out, MSB first
//   miso         flash serial data in
//   rd_data      assembled byte
//   rd_valid     rd_data holds an unconsumed byte
//   rd_ready     consumer accepts rd_data when rd_valid && rd_ready
//   busy         high from accepted start until done
//   done         one-cycle pulse at end of transfer
module t05_spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 24,
    parameter int CNT_W   = 24
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  byte_count,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);

    localparam int TX_W  = 8 + ADDR_W;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(((ADDR_W > 8) ? ADDR_W : 8) + 1);

    localparam logic [DIV_W-1:0] DIV_MAX       = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BYTE_BIT = BIT_W'(7);
    localparam logic [BIT_W-1:0] LAST_ADDR_BIT = BIT_W'(ADDR_W - 1);

`ifdef T05_SPI_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        HOLD,
        FINISH
`ifdef T05_SPI_FAST_READ_EN
        , DUMMY
`endif
    } state_t;

    state_t state, state_next;

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] remaining;
    logic [TX_W-1:0]  tx_sr;
    logic [7:0]       rx_sr;

    logic active;
    logic div_tick;
    logic sclk_rise;
    logic sclk_fall;
    logic next_selected;

    // Next-state logic. The sclk edge strobes are decoded from the divider,
    // and they exist only in the states that toggle sclk.
    always_comb begin
        state_next = state;
        active     = 1'b0;
        div_tick   = 1'b0;
        sclk_rise  = 1'b0;
        sclk_fall  = 1'b0;

        active = (state == CMD) || (state == ADDR) || (state == DATA)
`ifdef T05_SPI_FAST_READ_EN
                 || (state == DUMMY)
`endif
                 ;
        div_tick  = active && (div_cnt == DIV_MAX);
        sclk_rise = div_tick && !sclk;
        sclk_fall = div_tick && sclk;

        case (state)
            IDLE: begin
                if (start) state_next = CMD;
            end
            CMD: begin
                if (sclk_fall && (bit_cnt == LAST_BYTE_BIT)) state_next = ADDR;
            end
            ADDR: begin
                if (sclk_fall && (bit_cnt == LAST_ADDR_BIT)) begin
                    if (remaining == '0)
                        state_next = FINISH;
                    else
`ifdef T05_SPI_FAST_READ_EN
                        state_next = DUMMY;
`else
                        state_next = DATA;
`endif
                end
            end
`ifdef T05_SPI_FAST_READ_EN
            DUMMY: begin
                if (sclk_fall && (bit_cnt == LAST_BYTE_BIT)) state_next = DATA;
            end
`endif
            DATA: begin
                // The final byte always ends the transfer, even if the
                // consumer has not taken it yet. rd_valid simply persists.
                if (sclk_fall && (bit_cnt == LAST_BYTE_BIT)) begin
                    if (remaining == '0)
                        state_next = FINISH;
                    else if (rd_valid && !rd_ready)
                        state_next = HOLD;
                end
            end
            HOLD: begin
                if (rd_valid && rd_ready) state_next = DATA;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. cs_n, busy and done are registered decodes of the
    // next state, so they change on the same edge as the state.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state <= IDLE;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cs_n  <= (state_next == IDLE) || (state_next == FINISH);
            busy  <= (state_next != IDLE) && (state_next != FINISH);
            done  <= (state_next == FINISH);
        end
    end

    assign next_selected = (state_next == CMD) || (state_next == ADDR);

    // Bit timing, handshake and byte capture.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            remaining <= '0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
        end else begin
            // Acceptance clears rd_valid. A capture in the same cycle
            // overrides this below, so the new byte wins.
            if (rd_valid && rd_ready) rd_valid <= 1'b0;

            if (state == IDLE) begin
                sclk    <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                if (start) begin
                    remaining <= byte_count;
                    mosi      <= CMD_BYTE[7];
                end
            end else if (active) begin
                div_cnt <= div_tick ? '0 : div_cnt + DIV_W'(1);

                if (sclk_rise) begin
                    sclk <= 1'b1;
                    if ((state == DATA) && (bit_cnt == LAST_BYTE_BIT)) begin
                        rd_data   <= {rx_sr[6:0], miso};
                        rd_valid  <= 1'b1;
                        remaining <= remaining - CNT_W'(1);
                    end
                end

                if (sclk_fall) begin
                    sclk <= 1'b0;
                    if ((state_next != state) || (bit_cnt == LAST_BYTE_BIT && state == DATA))
                        bit_cnt <= '0;
                    else
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    mosi <= next_selected ? tx_sr[TX_W-2] : 1'b0;
                end
            end else begin
                // HOLD and FINISH: park sclk low and freeze the divider.
                sclk    <= 1'b0;
                div_cnt <= '0;
            end
        end
    end

    // Shift registers. These are pure data paths and have no reset.
    always_ff @(posedge hwclk) begin
        if ((state == IDLE) && start)
            tx_sr <= {CMD_BYTE, start_addr};
        else if (sclk_fall)
            tx_sr <= tx_sr << 1;

        if (sclk_rise && (state == DATA))
            rx_sr <= {rx_sr[6:0], miso};
    end

endmodule

// File: tb/tb_t05_spi_flash_reader.sv
`timescale 1ns/1ps
module tb_t05_spi_flash_reader;

    localparam int CLK_DIV = 2;
    localparam int ADDR_W  = 24;
    localparam int CNT_W   = 24;
`ifdef T05_SPI_FAST_READ_EN
    localparam int         HDR   = 40;
    localparam logic [7:0] CMD_B = 8'h0B;
`else
    localparam int         HDR   = 32;
    localparam logic [7:0] CMD_B = 8'h03;
`endif

    logic        hwclk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        miso = 1'b0;
    logic        rd_ready = 1'b0;
    logic [23:0] start_addr = '0;
    logic [23:0] byte_count = '0;
    logic        sclk, cs_n, mosi, rd_valid, busy, done;
    logic [7:0]  rd_data;

    t05_spi_flash_reader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .hwclk(hwclk), .reset(reset), .start(start), .start_addr(start_addr),
        .byte_count(byte_count), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy), .done(done)
    );

    always #5 hwclk = ~hwclk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] flash_mem [0:7];

    // Flash model / bus monitor state
    logic        sclk_q = 1'b0;
    logic        cs_q = 1'b1;
    int          nrise = 0, nfall = 0, cs_low = 0, post_ones = 0, k = 0;
    logic [31:0] hdr_word = '0;
    int          done_cnt = 0, valid_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Mode-0 flash: capture mosi on sclk rise, present next miso bit after sclk fall.
    always @(negedge hwclk) begin
        if (cs_n === 1'b0) begin
            if (cs_q) begin
                nrise = 0; nfall = 0; cs_low = 0; post_ones = 0; hdr_word = '0;
            end
            cs_low++;
            if (sclk && !sclk_q) begin
                nrise++;
                if (nrise <= 32) hdr_word = {hdr_word[30:0], mosi};
                else if (mosi) post_ones++;
            end
            if (!sclk && sclk_q) begin
                nfall++;
                if (nfall >= HDR) begin
                    k = nfall - HDR;
                    miso = flash_mem[(k / 8) % 8][7 - (k % 8)];
                end else begin
                    miso = 1'b0;
                end
            end
        end else begin
            miso = 1'b0;
        end
        cs_q   = (cs_n === 1'b0) ? 1'b0 : 1'b1;
        sclk_q = (sclk === 1'b1);
    end

    // Scoreboard monitor: every accepted byte is compared against the queue.
    always @(negedge hwclk) begin
        if (done === 1'b1) done_cnt++;
        if (rd_valid === 1'b1) valid_cyc++;
        if (!reset && rd_valid === 1'b1 && rd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: actual=0x%0h required=none", rd_data);
            end else begin
                chk("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic issue(input logic [23:0] a, input logic [23:0] n);
        start_addr = a;
        byte_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int c;
        c = 0;
        while (done !== 1'b1 && c < limit) begin
            tick();
            c++;
        end
        chk(name, {31'h0, done}, 32'h1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, v0, c, stall_bad, nr_a;
        for (int i = 0; i < 8; i++) flash_mem[i] = 8'h00;

        // Reset state
        repeat (3) tick();
        chk("rst_sclk", {31'h0, sclk}, 32'h0);
        chk("rst_cs_n", {31'h0, cs_n}, 32'h1);
        chk("rst_mosi", {31'h0, mosi}, 32'h0);
        chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        reset = 1'b0;
        tick();

        // 1: zero-length read, header only
        d0 = done_cnt; v0 = valid_cyc;
        issue(24'h000100, 24'd0);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        wait_done("t1_done_seen", 1000);
        chk("t1_header", hdr_word, 32'h03000100 | {CMD_B ^ 8'h03, 24'h0});
        chk("t1_cs_low", cs_low, 32'd128);
        chk("t1_sclk_cycles", nrise, 32'd32);
        chk("t1_done_pulses", done_cnt - d0, 32'd1);
        chk("t1_no_valid", valid_cyc - v0, 32'd0);

        // 2: one byte, consumer always ready
        flash_mem[0] = 8'h41;
        rd_ready = 1'b1;
        exp_q.push_back(8'h41);
        d0 = done_cnt; v0 = valid_cyc;
        issue(24'h000200, 24'd1);
        wait_done("t2_done_seen", 2000);
        chk("t2_header", hdr_word, {CMD_B, 24'h000200});
        chk("t2_sclk_cycles", nrise, HDR + 8);
        chk("t2_cs_low", cs_low, (HDR + 8) * 4);
        chk("t2_done_pulses", done_cnt - d0, 32'd1);
        chk("t2_valid_cycles", valid_cyc - v0, 32'd1);
        chk("t2_mosi_quiet", post_ones, 32'd0);

        // 3: three bytes with a 50-cycle consumer stall after the first
        flash_mem[0] = 8'h41; flash_mem[1] = 8'h42; flash_mem[2] = 8'h43;
        rd_ready = 1'b0;
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
        d0 = done_cnt;
        issue(24'h000300, 24'd3);
        c = 0;
        while (rd_valid !== 1'b1 && c < 2000) begin tick(); c++; end
        chk("t3_first_valid", {31'h0, rd_valid}, 32'h1);
        stall_bad = 0;
        nr_a = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 4) nr_a = nrise;
            if (i >= 4 && (sclk !== 1'b0 || cs_n !== 1'b0 || rd_valid !== 1'b1)) stall_bad++;
        end
        chk("t3_stall_bus", stall_bad, 32'd0);
        chk("t3_stall_frozen", nrise - nr_a, 32'd0);
        rd_ready = 1'b1;
        wait_done("t3_done_seen", 2000);
        chk("t3_done_pulses", done_cnt - d0, 32'd1);
        chk("t3_all_bytes", exp_q.size(), 32'd0);

        // 4: start while busy is ignored; a start after done is honoured
        flash_mem[0] = 8'h10; flash_mem[1] = 8'h20;
        exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        d0 = done_cnt;
        issue(24'h0A0B0C, 24'd2);
        repeat (20) tick();
        issue(24'hFFFFFF, 24'd5);
        wait_done("t4_done_seen", 2000);
        chk("t4_header", hdr_word, {CMD_B, 24'h0A0B0C});
        chk("t4_sclk_cycles", nrise, HDR + 16);
        chk("t4_done_pulses", done_cnt - d0, 32'd1);
        chk("t4_bytes", exp_q.size(), 32'd0);
        flash_mem[0] = 8'h5A;
        exp_q.push_back(8'h5A);
        issue(24'h123456, 24'd1);
        wait_done("t4b_done_seen", 2000);
        chk("t4b_header", hdr_word, {CMD_B, 24'h123456});
        chk("t4b_sclk_cycles", nrise, HDR + 8);
        chk("t4b_bytes", exp_q.size(), 32'd0);

        // 5: reset while sampling data bit 5 aborts silently
        flash_mem[0] = 8'hC3;
        d0 = done_cnt;
        issue(24'h000500, 24'd2);
        c = 0;
        while (nrise != HDR + 6 && c < 2000) begin tick(); c++; end
        chk("t5_reached_bit5", nrise, HDR + 6);
        reset = 1'b1;
        tick();
        chk("t5_cs_n", {31'h0, cs_n}, 32'h1);
        chk("t5_sclk", {31'h0, sclk}, 32'h0);
        chk("t5_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_done", {31'h0, done}, 32'h0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("t5_no_done_pulse", done_cnt - d0, 32'd0);
        chk("t5_idle_busy", {31'h0, busy}, 32'h0);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
